// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared encodings for the memory-stage controller
// Pointer modes, target select one-hots, error flag bit positions and FSM states.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MODE_NONE    = 2'b00,
    MODE_POSTINC = 2'b01,
    MODE_PREDEC  = 2'b10,
    MODE_LOAD    = 2'b11
  } ptr_mode_t;

  localparam logic [2:0] SEL_MAIN  = 3'b001;
  localparam logic [2:0] SEL_FRAME = 3'b010;
  localparam logic [2:0] SEL_PROG  = 3'b100;

  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;
  localparam int ERR_MULTI_SEL = 2;
  localparam int ERR_TIMEOUT   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_access_unit_call_stack.sv
// rtl/mem_access_unit_call_stack.sv - call_stack_lifo: return-address stack
// Push is ignored when full and pop when empty; the parent reports those as errors.
module call_stack_lifo #(
  parameter int DEPTH = 16,
  parameter int W     = 14
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] top_idx;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign top_idx = IDX_W'(sp - SP_W'(1));
  assign top     = mem[top_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full && !reset) begin
      mem[IDX_W'(sp)] <= wdata;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage controller: pointer file, call stack, external req/ack
// Optional ack watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int NUM_PTRS       = 4,
  parameter int CALL_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              mem_wen_in,
  input  logic              main_mem_en_in,
  input  logic              frame_buf_en_in,
  input  logic              prog_mem_en_in,
  input  logic              call_stack_en_in,
  input  logic [6:0]        mem_ptr_ctl_in,
  input  logic [7:0]        op_top_in,
  input  logic [7:0]        op_bot_in,
  input  logic [13:0]       ret_addr_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        rd_data_out,
  output logic              rd_valid_out,
  output logic [13:0]       ret_addr_out,
  output logic              ret_valid_out,
  output logic              stall,
  output logic [3:0]        err_flags
);
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int PI_W  = $clog2(NUM_PTRS);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state;
  logic [ADDR_W-1:0] ptrs [NUM_PTRS];
  logic              rd_pending;
  logic [TMO_W-1:0]  tmo_cnt;

  ptr_mode_t         mode;
  logic [PI_W-1:0]   pidx;
  logic [ADDR_W-1:0] ptr_cur, base, addr_calc;
  logic              accept, mem_op, multi, prog_wr, ext, push, pop;
  logic              t_main, t_frame, t_prog, t_call;
  logic [2:0]        sel;
  logic [13:0]       stk_top;
  logic              stk_full, stk_empty;

  always_comb begin
    mode      = ptr_mode_t'(mem_ptr_ctl_in[3:2]);
    pidx      = mem_ptr_ctl_in[PI_W-1:0];
    ptr_cur   = ptrs[pidx];
    base      = (mode == MODE_PREDEC) ? ptr_cur - ADDR_W'(1) : ptr_cur;
    addr_calc = base + {{(ADDR_W-3){mem_ptr_ctl_in[6]}}, mem_ptr_ctl_in[6:4]};
    accept    = valid_in && (state == ST_IDLE);
    mem_op    = accept && (mode != MODE_LOAD);
    // Fixed priority main > frame > prog > call; losers are dropped.
    t_main    = main_mem_en_in;
    t_frame   = frame_buf_en_in && !main_mem_en_in;
    t_prog    = prog_mem_en_in && !main_mem_en_in && !frame_buf_en_in;
    t_call    = call_stack_en_in && !main_mem_en_in && !frame_buf_en_in && !prog_mem_en_in;
    multi     = (main_mem_en_in && (frame_buf_en_in || prog_mem_en_in || call_stack_en_in)) ||
                (frame_buf_en_in && (prog_mem_en_in || call_stack_en_in)) ||
                (prog_mem_en_in && call_stack_en_in);
    prog_wr   = t_prog && mem_wen_in;
    ext       = mem_op && (t_main || t_frame || (t_prog && !mem_wen_in));
    push      = mem_op && t_call && mem_wen_in;
    pop       = mem_op && t_call && !mem_wen_in;
    sel       = t_main ? SEL_MAIN : (t_frame ? SEL_FRAME : SEL_PROG);
  end

  assign stall = ext || (state == ST_BUSY);

  call_stack_lifo #(.DEPTH(CALL_DEPTH), .W(14)) u_call_stack (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (ret_addr_in),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_sel       <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      rd_data_out   <= '0;
      rd_valid_out  <= 1'b0;
      ret_addr_out  <= '0;
      ret_valid_out <= 1'b0;
      err_flags     <= '0;
      rd_pending    <= 1'b0;
      tmo_cnt       <= '0;
      for (int i = 0; i < NUM_PTRS; i++) ptrs[i] <= '0;
    end else begin
      rd_valid_out  <= 1'b0;
      ret_valid_out <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          case (mode)
            MODE_POSTINC: ptrs[pidx] <= ptr_cur + ADDR_W'(1);
            MODE_PREDEC:  ptrs[pidx] <= base;
            MODE_LOAD:    ptrs[pidx] <= ADDR_W'({op_top_in, op_bot_in});
            default:      ;
          endcase
          if (mem_op && (multi || prog_wr)) err_flags[ERR_MULTI_SEL] <= 1'b1;
          if (push && stk_full) err_flags[ERR_OVERFLOW] <= 1'b1;
          if (pop) begin
            ret_valid_out <= 1'b1;
            ret_addr_out  <= stk_empty ? 14'h0 : stk_top;
            if (stk_empty) err_flags[ERR_UNDERFLOW] <= 1'b1;
          end
          if (ext) begin
            state      <= ST_BUSY;
            mem_req    <= 1'b1;
            mem_we     <= mem_wen_in;
            mem_sel    <= sel;
            mem_addr   <= addr_calc;
            mem_wdata  <= op_top_in;
            rd_pending <= !mem_wen_in;
            tmo_cnt    <= '0;
          end
        end
        default: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (rd_pending) begin
              rd_data_out  <= mem_rdata;
              rd_valid_out <= 1'b1;
            end
          end else if (TIMEOUT_EN && tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state                  <= ST_IDLE;
            mem_req                <= 1'b0;
            mem_we                 <= 1'b0;
            err_flags[ERR_TIMEOUT] <= 1'b1;
            if (rd_pending) begin
              rd_data_out  <= 8'hFF;
              rd_valid_out <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
// Watchdog case runs only when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access_unit;
  logic        clock, reset, valid_in, mem_wen_in;
  logic        main_mem_en_in, frame_buf_en_in, prog_mem_en_in, call_stack_en_in;
  logic [6:0]  mem_ptr_ctl_in;
  logic [7:0]  op_top_in, op_bot_in, mem_wdata, mem_rdata, rd_data_out;
  logic [13:0] ret_addr_in, ret_addr_out;
  logic        mem_req, mem_we, mem_ack, rd_valid_out, ret_valid_out, stall;
  logic [2:0]  mem_sel;
  logic [15:0] mem_addr;
  logic [3:0]  err_flags;

  int total = 0;
  int bad   = 0;
  logic [27:0] req_q[$];
  logic [7:0]  rd_q[$];
  logic [13:0] ret_q[$];

  mem_access_unit dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .mem_wen_in(mem_wen_in),
    .main_mem_en_in(main_mem_en_in), .frame_buf_en_in(frame_buf_en_in),
    .prog_mem_en_in(prog_mem_en_in), .call_stack_en_in(call_stack_en_in),
    .mem_ptr_ctl_in(mem_ptr_ctl_in), .op_top_in(op_top_in), .op_bot_in(op_bot_in),
    .ret_addr_in(ret_addr_in), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out), .ret_addr_out(ret_addr_out),
    .ret_valid_out(ret_valid_out), .stall(stall), .err_flags(err_flags)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a request or result.
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) check("req_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
        else check("mem_req", {mem_we, mem_sel, mem_addr, mem_wdata}, req_q.pop_front());
      end
      prev_req = mem_req;
      if (rd_valid_out) begin
        if (rd_q.size() == 0) check("rd_unexpected", 32'(rd_data_out), 32'hFFFF_FFFF);
        else check("rd_data", rd_data_out, rd_q.pop_front());
      end
      if (ret_valid_out) begin
        if (ret_q.size() == 0) check("ret_unexpected", 32'(ret_addr_out), 32'hFFFF_FFFF);
        else check("ret_addr", ret_addr_out, ret_q.pop_front());
      end
    end
  end

  task automatic drive(input bit wen, input logic [3:0] tgt, input logic [6:0] ctl,
                       input logic [7:0] top, input logic [7:0] bot, input logic [13:0] ra);
    valid_in = 1'b1;
    mem_wen_in = wen;
    {call_stack_en_in, prog_mem_en_in, frame_buf_en_in, main_mem_en_in} = tgt;
    mem_ptr_ctl_in = ctl;
    op_top_in = top;
    op_bot_in = bot;
    ret_addr_in = ra;
  endtask

  task automatic idle_in();
    drive(1'b0, 4'b0000, 7'h00, 8'h00, 8'h00, 14'h0);
    valid_in = 1'b0;
  endtask

  task automatic simple_op(input bit wen, input logic [3:0] tgt, input logic [6:0] ctl,
                           input logic [7:0] top, input logic [7:0] bot, input logic [13:0] ra);
    @(negedge clock);
    drive(wen, tgt, ctl, top, bot, ra);
    @(negedge clock);
    idle_in();
  endtask

  task automatic ext_op(input bit wen, input logic [3:0] tgt, input logic [6:0] ctl,
                        input logic [7:0] top, input logic [2:0] xsel, input logic [15:0] xaddr,
                        input int dly, input logic [7:0] rdata, input string nm);
    int sc;
    req_q.push_back({wen, xsel, xaddr, top});
    if (!wen) rd_q.push_back(rdata);
    @(negedge clock);
    drive(wen, tgt, ctl, top, 8'h00, 14'h0);
    #1 sc = int'(stall);
    for (int i = 1; i <= dly; i++) begin
      @(negedge clock);
      idle_in();
      if (i == dly) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      #1 if (stall) sc++;
    end
    @(negedge clock);
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    #1 if (stall) sc++;
    check({nm, "_stall"}, sc, dly + 1);
  endtask

  initial begin
    int sc;
    idle_in();
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_mem", {mem_req, mem_we, mem_sel, mem_addr, mem_wdata}, 0);
    check("rst_out", {rd_data_out, rd_valid_out, ret_addr_out, ret_valid_out, stall, err_flags}, 0);
    reset = 1'b0;

    simple_op(1'b1, 4'b0000, 7'b000_11_00, 8'h10, 8'hFF, 14'h0);
    ext_op(1'b0, 4'b0001, 7'b000_01_00, 8'h00, 3'b001, 16'h10FF, 3, 8'hA5, "postinc");
    ext_op(1'b0, 4'b0001, 7'b000_00_00, 8'h00, 3'b001, 16'h1100, 1, 8'h3C, "ptr0_after");
    ext_op(1'b1, 4'b0010, 7'b110_10_01, 8'h5A, 3'b010, 16'hFFFD, 2, 8'h00, "predec_wr");
    ext_op(1'b0, 4'b0010, 7'b000_00_01, 8'h00, 3'b010, 16'hFFFF, 1, 8'hC3, "ptr1_after");
    check("err_clean", err_flags, 4'b0000);

    @(negedge clock);
    drive(1'b1, 4'b0100, 7'b000_00_11, 8'h11, 8'h00, 14'h0);
    #1 check("prog_wr_stall", stall, 1'b0);
    @(negedge clock);
    idle_in();
    check("prog_wr_err", err_flags, 4'b0100);
    ext_op(1'b0, 4'b0100, 7'b011_00_11, 8'h00, 3'b100, 16'h0003, 2, 8'h77, "prog_rd");

    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("err_after_rst", err_flags, 4'b0000);

    ext_op(1'b0, 4'b0011, 7'b001_00_10, 8'h00, 3'b001, 16'h0001, 1, 8'h99, "multi");
    check("multi_err", err_flags, 4'b0100);

    for (int i = 0; i < 17; i++) simple_op(1'b1, 4'b1000, 7'h00, 8'h00, 8'h00, 14'(100 + i));
    check("overflow_err", err_flags, 4'b0110);
    for (int i = 0; i < 17; i++) begin
      ret_q.push_back((i < 16) ? 14'(115 - i) : 14'h0);
      simple_op(1'b0, 4'b1000, 7'h00, 8'h00, 8'h00, 14'h0);
    end
    check("underflow_err", err_flags, 4'b0111);

    req_q.push_back({1'b0, 3'b001, 16'h0000, 8'h00});
    @(negedge clock);
    drive(1'b0, 4'b0001, 7'h00, 8'h00, 8'h00, 14'h0);
    @(negedge clock);
    idle_in();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1 check("rst_busy_req", {mem_req, stall}, 2'b00);
    @(negedge clock);
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    @(negedge clock);
    mem_ack = 1'b0;
    #1 check("late_ack_rdv", {rd_valid_out, stall}, 2'b00);
    check("late_ack_err", err_flags, 4'b0000);

`ifdef MEM_ACCESS_TIMEOUT_EN
    req_q.push_back({1'b0, 3'b001, 16'h0000, 8'h00});
    rd_q.push_back(8'hFF);
    @(negedge clock);
    drive(1'b0, 4'b0001, 7'h00, 8'h00, 8'h00, 14'h0);
    #1 sc = int'(stall);
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      idle_in();
      #1 if (stall) sc++;
      else break;
    end
    check("tmo_stall", sc, 256);
    check("tmo_err", err_flags, 4'b1000);
`else
    sc = 0;
`endif

    repeat (3) @(negedge clock);
    check("req_q_empty", req_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("ret_q_empty", ret_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
